shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one 32-bit shift unit (SLL/SRL/SRA) between two requesters.
- Round-robin arbitration; one output register stage with a valid/ready response.
- Sits between the issue logic and the ALU result mux.
- Lets two issue slots use a single barrel shifter instead of two.

Parameters:
- WIDTH, 32, data width of a, b and result (power of two).
- SHAMT_W, 5, shift-amount bits taken from b (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand to shift
- req0_b  input  WIDTH  requester 0 shift amount; only b[SHAMT_W-1:0] is used
- req0_op  input  2  requester 0 op code
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- resp_valid  output  1  result register holds a valid result
- resp_ready  input  1  consumer takes the result this cycle
- resp_result  output  WIDTH  shifted value
- resp_id  output  1  which requester produced the result (0/1)

Behaviour:
- Op encoding (package): 00 SLL, 01 SRL (zero fill), 10 SRA (sign fill from a[WIDTH-1]), 11 reserved.
  - Reserved op without the optional feature: result is 0.
- Shift amount = b[SHAMT_W-1:0]; upper bits of b are ignored.
  - Example: b = 0x25 shifts by 5.
  - Shift by 0 returns a unchanged.
- Output buffer is a 2-state FSM:
  - EMPTY: resp_valid = 0.
  - FULL: resp_valid = 1; resp_result and resp_id are held stable.
- space = (state == EMPTY) || resp_ready.
- Arbitration uses a last_grant pointer.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
- reqN_ready = grantN && space.
  - Combinational from the valids and resp_ready.
  - At most one ready is high per cycle.
- On accept (reqN_valid && reqN_ready), at the clock edge:
  - The result register loads shift(aN, bN, opN).
  - resp_id <= N; last_grant <= N; state -> FULL.
- Latency: accept in cycle T gives resp_valid in cycle T+1.
  - Back-to-back throughput is 1 result per cycle when resp_ready is held high.
- FULL with resp_ready = 1 and no accept -> EMPTY.
- FULL with resp_ready = 1 and an accept -> stays FULL with the new result (no bubble).
- FULL with resp_ready = 0:
  - Both req_ready are 0; last_grant is unchanged.
  - resp_result and resp_id are unchanged.
- last_grant changes only on accept. A requester that was valid but not granted keeps its turn.
- Reset (rst_n = 0 at a clock edge):
  - state = EMPTY, resp_valid = 0, resp_result = 0, resp_id = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Reset while FULL discards the held result. req_ready outputs are 0 while rst_n = 0.

Optional Feature:
- Macro: SHIFT_ARBITER_ROTATE_EN.
- Defined: op 11 = ROL, rotate left by shamt; bits shifted out of the MSB re-enter at the LSB.
- Undefined: op 11 gives result 0, with the same timing and handshake as any other op.

Decomposition:
- Package shift_pkg:
  - shift_op_t enum: OP_SLL, OP_SRL, OP_SRA, OP_RSV_ROL.
  - Buffer-state enum: ST_EMPTY, ST_FULL.
  - Default WIDTH and SHAMT_W constants.
- One sub-module, shift_unit: purely combinational (a, b, op -> result).
  - Holds all shift and rotate logic, including the ROTATE_EN conditional.
  - The arbiter instantiates it once, on a muxed operand set.

Test Plan:
1. Basic shift: req0 a=0x00000001 b=1 SLL, resp_ready=1 -> next cycle resp_valid=1, result=0x00000002, id=0. Then req0 a=0x000008DF b=5 SLL -> result 0x00011BE0.
2. Tie and round-robin: after reset, both valid for two cycles; req0 a=0x00000002 b=2 SLL, req1 a=0x80000000 b=31 SRA -> results 0x00000008 (id 0) then 0xFFFFFFFF (id 1); each requester's ready pulses exactly once.
3. Backpressure: FULL with resp_ready=0 for 3 cycles while both requesters are valid -> result and id stable, both req_ready=0, last_grant unchanged. Then resp_ready=1 -> the same-cycle accept goes to the requester != last_grant.
4. Amount masking and edges: a=0x00000001 b=0x0000001F SLL -> 0x80000000; a=0x80000000 b=0x21 SRL -> 0x40000000; b=0 -> result equals a.
5. Reset mid-operation: drive rst_n=0 while FULL -> next cycle resp_valid=0, resp_result=0, and req0 wins the next tie.
6. Op 11 with a=0x80000001 b=1 -> 0x00000003 with SHIFT_ARBITER_ROTATE_EN defined; 0x00000000 without it.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and default sizes for the shared shift unit arbiter.
// The optional ROL op is enabled by SHIFT_ARBITER_ROTATE_EN.
package shift_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL     = 2'b00,
    OP_SRL     = 2'b01,
    OP_SRA     = 2'b10,
    OP_RSV_ROL = 2'b11
  } shift_op_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/shift_unit.sv
// Combinational barrel shifter: SLL, SRL, SRA and optional ROL.
// Op 11 is ROL with SHIFT_ARBITER_ROTATE_EN defined, otherwise it yields 0.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_op_t          op,
  output logic [WIDTH-1:0]   result
);

`ifdef SHIFT_ARBITER_ROTATE_EN
  logic [2*WIDTH-1:0] dbl;
  assign dbl = {a, a} << shamt;
`endif

  always_comb begin
    result = '0;
    unique case (op)
      OP_SLL: result = a << shamt;
      OP_SRL: result = a >> shamt;
      OP_SRA: result = WIDTH'($signed(a) >>> shamt);
`ifdef SHIFT_ARBITER_ROTATE_EN
      OP_RSV_ROL: result = dbl[2*WIDTH-1:WIDTH];
`else
      OP_RSV_ROL: result = '0;
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_unit between two requesters,
// with a single registered valid/ready response. Option: SHIFT_ARBITER_ROTATE_EN.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_id
);

  buf_state_t state, state_nx;
  logic last_grant;
  logic space, grant0, grant1, accept;

  logic [WIDTH-1:0]   sel_a;
  logic [SHAMT_W-1:0] sel_sh;
  shift_op_t          sel_op;
  logic [WIDTH-1:0]   sh_res;

  // Only the low shamt bits of b matter.
  logic unused_b;
  assign unused_b = ^{req0_b[WIDTH-1:SHAMT_W], req1_b[WIDTH-1:SHAMT_W]};

  assign space  = (state == ST_EMPTY) || resp_ready;
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = rst_n && space && grant0;
  assign req1_ready = rst_n && space && grant1;
  assign accept     = req0_ready || req1_ready;
  assign resp_valid = (state == ST_FULL);

  always_comb begin
    sel_a  = req0_a;
    sel_sh = req0_b[SHAMT_W-1:0];
    sel_op = shift_op_t'(req0_op);
    if (req1_ready) begin
      sel_a  = req1_a;
      sel_sh = req1_b[SHAMT_W-1:0];
      sel_op = shift_op_t'(req1_op);
    end
  end

  shift_unit #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .a      (sel_a),
    .shamt  (sel_sh),
    .op     (sel_op),
    .result (sh_res)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_EMPTY: if (accept) state_nx = ST_FULL;
      ST_FULL:  if (!accept && resp_ready) state_nx = ST_EMPTY;
      default:  state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      resp_result <= '0;
      resp_id     <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      state <= state_nx;
      if (accept) begin
        resp_result <= sh_res;
        resp_id     <= req1_ready;
        last_grant  <= req1_ready;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table plus handshake sequences.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] result;
    logic        id;
  } exp_t;

  typedef struct {
    logic        req;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  exp_t q[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  shift_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_id     (resp_id)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic push(input logic [31:0] r, input logic id);
    exp_t e;
    e.result = r;
    e.id     = id;
    q.push_back(e);
  endtask

  task automatic idle();
    req0_valid = 0;
    req1_valid = 0;
  endtask

  // Scoreboard: every consumed response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got %h id %0d", resp_result, resp_id);
      end else begin
        e = q.pop_front();
        if (resp_result !== e.result || resp_id !== e.id) begin
          errors++;
          $display("FAIL resp got %h id %0d want %h id %0d",
                   resp_result, resp_id, e.result, e.id);
        end
      end
    end
  end

  initial begin
    logic [31:0] held;
    vecs[0] = '{1'b0, 32'h00000001, 32'h1,  2'b00, 32'h00000002};
    vecs[1] = '{1'b0, 32'h000008DF, 32'h5,  2'b00, 32'h00011BE0};
    vecs[2] = '{1'b1, 32'h00000001, 32'h1F, 2'b00, 32'h80000000};
    vecs[3] = '{1'b0, 32'h80000000, 32'h21, 2'b01, 32'h40000000};
    vecs[4] = '{1'b1, 32'h12345678, 32'h0,  2'b10, 32'h12345678};
    vecs[5] = '{1'b0, 32'hF0000000, 32'h4,  2'b10, 32'hFF000000};
    vecs[6] = '{1'b1, 32'hF0000000, 32'h4,  2'b01, 32'h0F000000};
    vecs[7] = '{1'b0, 32'h80000001, 32'h25, 2'b10, 32'hFC000000};
    vecs[8] = '{1'b1, 32'hCAFEF00D, 32'h0,  2'b00, 32'hCAFEF00D};
`ifdef SHIFT_ARBITER_ROTATE_EN
    vecs[9] = '{1'b0, 32'h80000001, 32'h1,  2'b11, 32'h00000003};
`else
    vecs[9] = '{1'b0, 32'h80000001, 32'h1,  2'b11, 32'h00000000};
`endif

    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    resp_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_id", {31'b0, resp_id}, 32'd0);
    chk("rst_rdy", {30'b0, req1_ready, req0_ready}, 32'd0);
    idle();
    @(posedge clk) #1 rst_n = 1;

    // Vector table, one requester at a time, back-to-back.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1;
      req0_valid = !vecs[i].req;
      req1_valid = vecs[i].req;
      req0_a = vecs[i].a; req0_b = vecs[i].b; req0_op = vecs[i].op;
      req1_a = vecs[i].a; req1_b = vecs[i].b; req1_op = vecs[i].op;
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), {30'b0, req1_ready, req0_ready},
          vecs[i].req ? 32'd2 : 32'd1);
      push(vecs[i].exp, vecs[i].req);
    end
    @(posedge clk) #1 idle();

    // Tie after reset: req0 first, then req1.
    @(posedge clk) #1 rst_n = 0;
    @(posedge clk) #1 rst_n = 1;
    req0_valid = 1; req0_a = 32'h2; req0_b = 32'h2; req0_op = 2'b00;
    req1_valid = 1; req1_a = 32'h80000000; req1_b = 32'd31; req1_op = 2'b10;
    @(negedge clk);
    chk("tie_c1", {30'b0, req1_ready, req0_ready}, 32'd1);
    push(32'h00000008, 1'b0);
    @(negedge clk);
    chk("tie_c2", {30'b0, req1_ready, req0_ready}, 32'd2);
    push(32'hFFFFFFFF, 1'b1);
    @(posedge clk) #1 idle();

    // Backpressure while FULL.
    @(posedge clk) #1;
    resp_ready = 0;
    req0_valid = 1; req0_a = 32'h0000ABCD; req0_b = 32'h4; req0_op = 2'b00;
    @(negedge clk);
    chk("bp_acc", {30'b0, req1_ready, req0_ready}, 32'd1);
    push(32'h000ABCD0, 1'b0);
    @(posedge clk) #1;
    req1_valid = 1; req1_a = 32'h00000100; req1_b = 32'h8; req1_op = 2'b01;
    held = 32'h000ABCD0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_rdy", {30'b0, req1_ready, req0_ready}, 32'd0);
      chk("bp_hold", resp_result, held);
      chk("bp_vid", {30'b0, resp_valid, resp_id}, 32'd2);
    end
    @(posedge clk) #1 resp_ready = 1;
    @(negedge clk);
    chk("bp_rel", {30'b0, req1_ready, req0_ready}, 32'd2);
    push(32'h00000001, 1'b1);
    @(posedge clk) #1 idle();

    // Reset while FULL discards the result and restores req0 priority.
    @(posedge clk) #1;
    resp_ready = 0;
    req0_valid = 1; req0_a = 32'h5; req0_b = 32'h1; req0_op = 2'b00;
    @(posedge clk) #1;
    idle();
    @(negedge clk);
    chk("rm_full", {31'b0, resp_valid}, 32'd1);
    @(posedge clk) #1;
    rst_n = 0;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("rm_rdy_low", {30'b0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk) #1;
    idle();
    @(negedge clk);
    chk("rm_valid", {31'b0, resp_valid}, 32'd0);
    chk("rm_result", resp_result, 32'd0);
    @(posedge clk) #1;
    rst_n = 1; resp_ready = 1;
    req0_valid = 1; req0_a = 32'h3; req0_b = 32'h40; req0_op = 2'b01;
    req1_valid = 1;
    @(negedge clk);
    chk("rm_tie", {30'b0, req1_ready, req0_ready}, 32'd1);
    push(32'h00000003, 1'b0);
    @(posedge clk) #1 idle();

    for (int w = 0; w < 10 && q.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    chk("drain", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
